// File: rtl/stack_exec_seq.sv
// stack_exec_seq: runs one WASM i32 stack instruction against the operand stack; ports: clk, reset, start/opcode/imm in, ready/done/trap_code out, stack_op/stack_data to stack, stack_tos/stack_status from stack
module stack_exec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] imm,
  output logic             ready,
  output logic             done,
  output logic [1:0]       trap_code,
  output logic [1:0]       stack_op,
  output logic [WIDTH-1:0] stack_data,
  input  logic [WIDTH-1:0] stack_tos,
  input  logic [1:0]       stack_status
);
  localparam logic [1:0] OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_REPLACE = 2'd3;
  localparam logic [1:0] ST_EMPTY = 2'd1, ST_FULL = 2'd2;
  localparam logic [1:0] T_OK = 2'd0, T_UNDER = 2'd1, T_OVER = 2'd2, T_ILL = 2'd3;
  typedef enum logic [2:0] {IDLE, POP_B, LOAD_A, RESTORE, WRITE, FINISH} state_t;
  state_t state, state_n;
  logic [7:0] op_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, result;
  logic [1:0] trap_q, trap_n;
  logic [$clog2(WIDTH)-1:0] shamt;
  logic in_const, in_unary, in_binary, q_const, q_drop;
  function automatic logic is_binary(input logic [7:0] o);
    return o inside {8'h46, 8'h47, 8'h49, 8'h4B, 8'h6A, 8'h6B, 8'h6C, 8'h71, 8'h72, 8'h73, 8'h74, 8'h76};
  endfunction
  assign in_const  = opcode == 8'h41;
  assign in_unary  = opcode == 8'h1A || opcode == 8'h45;
  assign in_binary = is_binary(opcode);
  assign q_const   = op_q == 8'h41;
  assign q_drop    = op_q == 8'h1A;
  assign shamt     = b_q[$clog2(WIDTH)-1:0];
  always_comb begin
    state_n = state;
    trap_n  = trap_q;
    unique case (state)
      IDLE: if (start) begin
        trap_n  = !(in_const || in_unary || in_binary) ? T_ILL :
                  in_const ? (stack_status == ST_FULL ? T_OVER : T_OK) :
                  (stack_status == ST_EMPTY ? T_UNDER : T_OK);
        state_n = trap_n != T_OK ? FINISH : in_binary ? POP_B : WRITE;
      end
      POP_B:   state_n = LOAD_A;
      LOAD_A:  state_n = stack_status == ST_EMPTY ? RESTORE : WRITE;
      RESTORE: begin
        state_n = FINISH;
        trap_n  = T_UNDER;
      end
      WRITE:   state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    result = '0;
    case (op_q)
      8'h45:   result = WIDTH'(b_q == '0);
      8'h46:   result = WIDTH'(a_q == b_q);
      8'h47:   result = WIDTH'(a_q != b_q);
      8'h49:   result = WIDTH'(a_q < b_q);
      8'h4B:   result = WIDTH'(a_q > b_q);
      8'h6A:   result = a_q + b_q;
      8'h6B:   result = a_q - b_q;
      8'h6C:   result = a_q * b_q;
      8'h71:   result = a_q & b_q;
      8'h72:   result = a_q | b_q;
      8'h73:   result = a_q ^ b_q;
      8'h74:   result = a_q << shamt;
      8'h76:   result = a_q >> shamt;
      default: result = '0;
    endcase
  end
  assign ready      = state == IDLE;
  assign done       = state == FINISH;
  assign trap_code  = done ? trap_q : T_OK;
  assign stack_op   = state == POP_B ? OP_POP : state == RESTORE ? OP_PUSH :
                      state == WRITE ? (q_const ? OP_PUSH : q_drop ? OP_POP : OP_REPLACE) : OP_NONE;
  // RESTORE pushes the popped top back so an underflow leaves the stack untouched
  assign stack_data = state == RESTORE ? b_q :
                      state == WRITE ? (q_const ? imm_q : q_drop ? '0 : result) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      trap_q <= T_OK;
    end else begin
      state  <= state_n;
      trap_q <= trap_n;
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_q  <= opcode;
      imm_q <= imm;
      b_q   <= stack_tos;
    end
    if (state == LOAD_A) a_q <= stack_tos;
  end
endmodule

// File: tb/tb_stack_exec_seq.sv
// tb_stack_exec_seq: drives stack_exec_seq against a 3-entry stack and a queue-based instruction model
module tb_stack_exec_seq;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] opcode = 0, imm = 0, stack_data, stack_tos;
  logic ready, done;
  logic [1:0] trap_code, stack_op, stack_status;
  logic [7:0] mem [3];
  int cnt = 0, checks = 0, failures = 0;
  int ref_q[$];

  stack_exec_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .imm(imm),
    .ready(ready), .done(done), .trap_code(trap_code), .stack_op(stack_op),
    .stack_data(stack_data), .stack_tos(stack_tos), .stack_status(stack_status));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else case (stack_op)
      2'd1: if (cnt < 3) begin mem[cnt] <= stack_data; cnt <= cnt + 1; end
      2'd2: if (cnt > 0) cnt <= cnt - 1;
      2'd3: if (cnt > 0) mem[cnt-1] <= stack_data;
      default: ;
    endcase
  end
  always_comb begin
    stack_tos = cnt > 0 ? mem[cnt-1] : 8'd0;
    stack_status = cnt == 0 ? 2'd1 : cnt == 3 ? 2'd2 : 2'd0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    chk("stack_legal", int'((stack_op == 2'd1 && cnt == 3) || (stack_op[1] && cnt == 0)), 0);
    if (stack_op == 2'd0) chk("data_zero_when_idle", stack_data, 0);
    if (done) chk("done_not_ready", ready, 0);
  end

  function automatic bit binop(input logic [7:0] o);
    return o inside {8'h46, 8'h47, 8'h49, 8'h4B, 8'h6A, 8'h6B, 8'h6C, 8'h71, 8'h72, 8'h73, 8'h74, 8'h76};
  endfunction

  function automatic int alu(input logic [7:0] o, input int a, input int b);
    case (o)
      8'h46: return int'(a == b);
      8'h47: return int'(a != b);
      8'h49: return int'(a < b);
      8'h4B: return int'(a > b);
      8'h6A: return (a + b) % 256;
      8'h6B: return (a - b + 256) % 256;
      8'h6C: return (a * b) % 256;
      8'h71: return a & b;
      8'h72: return a | b;
      8'h73: return a ^ b;
      8'h74: return (a << (b % 8)) % 256;
      default: return a >> (b % 8);
    endcase
  endfunction

  // expected trap, done latency and number of stack ops; updates ref_q on success
  task automatic predict(input logic [7:0] o, input logic [7:0] iv, output int t, output int l, output int n);
    int a, b;
    t = 0; l = 1; n = 0;
    if (o == 8'h41) begin
      if (ref_q.size() == 3) t = 2;
      else begin ref_q.push_back(int'(iv)); l = 2; n = 1; end
    end else if (o == 8'h1A || o == 8'h45) begin
      if (ref_q.size() == 0) t = 1;
      else begin
        b = ref_q.pop_back();
        if (o == 8'h45) ref_q.push_back(int'(b == 0));
        l = 2; n = 1;
      end
    end else if (binop(o)) begin
      if (ref_q.size() == 0) t = 1;
      else if (ref_q.size() == 1) begin t = 1; l = 4; n = 2; end
      else begin
        b = ref_q.pop_back();
        a = ref_q.pop_back();
        ref_q.push_back(alu(o, a, b));
        l = 4; n = 2;
      end
    end else t = 3;
  endtask

  task automatic exec(input logic [7:0] o, input logic [7:0] iv, input int exp_tos, input bit poke);
    int et, el, en, lat, nops, tc, extra;
    bit seen, same;
    predict(o, iv, et, el, en);
    @(negedge clk);
    opcode = o; imm = iv; start = 1;
    @(posedge clk);
    lat = 0; nops = 0; seen = 0; tc = -1;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      start = 0;
      if (poke && lat == 1) begin start = 1; opcode = 8'h00; end
      if (stack_op != 2'd0) nops++;
      if (done) begin seen = 1; tc = trap_code; end
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, el);
    chk("trap_code", tc, et);
    chk("stack_op_count", nops, en);
    same = cnt == ref_q.size();
    for (int i = 0; i < 3; i++) if (same && i < cnt) same = mem[i] == ref_q[i][7:0];
    chk("stack_contents", same, 1);
    if (exp_tos >= 0) chk("tos_literal", stack_tos, exp_tos);
    extra = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) extra++; end
    chk("no_extra_done", extra, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    ref_q.delete();
  endtask

  logic [7:0] t_op [9] = '{8'h46, 8'h47, 8'h49, 8'h4B, 8'h6C, 8'h71, 8'h72, 8'h73, 8'h76};
  logic [7:0] t_a  [9] = '{8'd7, 8'd7, 8'd3, 8'd3, 8'd20, 8'hF0, 8'hF0, 8'hF0, 8'h80};
  logic [7:0] t_b  [9] = '{8'd7, 8'd7, 8'd200, 8'd200, 8'd13, 8'h3C, 8'h0F, 8'h3C, 8'h0B};
  int t_r [9] = '{1, 0, 1, 0, 4, 'h30, 'hFF, 'hCC, 'h10};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_trap", trap_code, 0);
    chk("rst_op", stack_op, 0);
    chk("rst_data", stack_data, 0);
    reset = 0;
    // 1: add
    exec(8'h41, 8'd5, 5, 0);
    exec(8'h41, 8'd3, 3, 0);
    exec(8'h6A, 8'd0, 8'h08, 0);
    chk("status_after_add", stack_status, 0);
    // 2: sub wraps, shl uses b mod 8
    do_reset();
    exec(8'h41, 8'd3, -1, 0);
    exec(8'h41, 8'd5, -1, 0);
    exec(8'h6B, 8'd0, 8'hFE, 0);
    exec(8'h41, 8'h81, -1, 0);
    exec(8'h41, 8'd9, -1, 0);
    exec(8'h74, 8'd0, 8'h02, 0);
    // 3: underflow found in LOAD_A, then empty-stack underflow
    do_reset();
    exec(8'h41, 8'd7, -1, 0);
    exec(8'h6A, 8'd0, 8'h07, 0);
    do_reset();
    exec(8'h6A, 8'd0, -1, 0);
    // 4: overflow on a full stack
    do_reset();
    exec(8'h41, 8'd0, -1, 0);
    exec(8'h41, 8'd1, -1, 0);
    exec(8'h41, 8'd2, -1, 0);
    chk("status_full", stack_status, 2);
    exec(8'h41, 8'd9, 8'h02, 0);
    // 5: eqz with a start pulse while busy, illegal opcode, drop
    do_reset();
    exec(8'h41, 8'd0, -1, 0);
    exec(8'h45, 8'd0, 8'h01, 1);
    exec(8'h00, 8'd0, 8'h01, 0);
    exec(8'h45, 8'd0, 8'h00, 0);
    exec(8'h1A, 8'd0, -1, 0);
    exec(8'h1A, 8'd0, -1, 0);
    // remaining binary ops
    for (int i = 0; i < 9; i++) begin
      do_reset();
      exec(8'h41, t_a[i], -1, 0);
      exec(8'h41, t_b[i], -1, 0);
      exec(t_op[i], 8'd0, t_r[i], 0);
    end
    // 6: reset during LOAD_A
    do_reset();
    exec(8'h41, 8'd5, -1, 0);
    exec(8'h41, 8'd3, -1, 0);
    @(negedge clk);
    opcode = 8'h6A; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    chk("pop_b_op", stack_op, 2);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_op", stack_op, 0);
    reset = 0;
    ref_q.delete();
    exec(8'h41, 8'd4, 4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
